// File: rtl/raizing_input_cond.sv
// rtl/raizing_input_cond.sv - synchroniser, debouncer, coin pulse shaper; autofire on bits 6:4 when RAIZING_AUTOFIRE_EN
// Bit map of the 28 conditioned inputs: coin 3:0, start 7:4, joy1 17:8, joy2 27:18.
module raizing_input_cond #(
  parameter int CLK_KHZ          = 48000,
  parameter int DEB_TICKS        = 4,
  parameter int COIN_PULSE_TICKS = 100,
  parameter int COIN_GAP_TICKS   = 100,
  parameter int AF_TICKS         = 33
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] COIN_RAW,
  input  logic [3:0] START_RAW,
  input  logic [9:0] JOY1_RAW,
  input  logic [9:0] JOY2_RAW,
  input  logic [2:0] AF_MASK,
  output logic [3:0] COIN_OUT,
  output logic [3:0] START_OUT,
  output logic [9:0] JOY1_OUT,
  output logic [9:0] JOY2_OUT,
  output logic       TICK
);

  localparam int NB = 28;
  localparam int TW = $clog2(CLK_KHZ + 1);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int CMAX = (COIN_PULSE_TICKS > COIN_GAP_TICKS) ? COIN_PULSE_TICKS : COIN_GAP_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int AW = $clog2(AF_TICKS + 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_e;

  logic [NB-1:0] raw, sync1_q, sync2_q, acc_q, acc_d;
  logic [DW-1:0] deb_q [NB];
  logic [DW-1:0] deb_d [NB];
  logic [TW-1:0] tcnt_q;
  logic          tick_q;
  logic [3:0]    press;

  assign raw  = {JOY2_RAW, JOY1_RAW, START_RAW, COIN_RAW};
  assign TICK = tick_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      acc_q   <= '1;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < NB; i++) deb_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      for (int i = 0; i < NB; i++) deb_q[i] <= deb_d[i];
      if (tcnt_q == TW'(CLK_KHZ - 1)) begin
        tcnt_q <= '0;
        tick_q <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
        tick_q <= 1'b0;
      end
    end
  end

  // Each bit needs DEB_TICKS consecutive disagreeing samples before the accepted level flips.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NB; i++) begin
      deb_d[i] = deb_q[i];
      if (tick_q) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (deb_q[i] == DW'(DEB_TICKS - 1)) begin
            deb_d[i] = '0;
            acc_d[i] = sync2_q[i];
          end else begin
            deb_d[i] = deb_q[i] + 1'b1;
          end
        end else begin
          deb_d[i] = '0;
        end
      end
    end
  end

  assign press     = acc_q[3:0] & ~acc_d[3:0];
  assign START_OUT = acc_q[7:4];

  for (genvar c = 0; c < 4; c++) begin : g_coin
    coin_st_e      st_q, st_d;
    logic [1:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec;
    logic          coin_lvl;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        st_q   <= C_IDLE;
        pend_q <= '0;
        cnt_q  <= '0;
      end else begin
        st_q   <= st_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      dec   = 1'b0;
      unique case (st_q)
        C_IDLE: if (pend_q != 2'd0) begin
          st_d  = C_PULSE;
          cnt_d = '0;
          dec   = 1'b1;
        end
        C_PULSE: if (tick_q) begin
          if (cnt_q == CW'(COIN_PULSE_TICKS - 1)) begin
            st_d  = C_GAP;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        C_GAP: if (tick_q) begin
          if (cnt_q == CW'(COIN_GAP_TICKS - 1)) begin
            st_d  = C_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: st_d = C_IDLE;
      endcase
      // A press landing on the same cycle as a dequeue cancels out.
      pend_d = pend_q;
      if (press[c] && !dec) begin
        if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
      end else if (!press[c] && dec) begin
        pend_d = pend_q - 2'd1;
      end
    end

    always_comb coin_lvl = (st_q != C_PULSE);
    assign COIN_OUT[c] = coin_lvl;
  end

`ifdef RAIZING_AUTOFIRE_EN
  logic [5:0]    af_act;
  logic [5:0]    af_ph_q;
  logic [AW-1:0] af_cnt_q [6];

  assign af_act = {~acc_q[24:22] & AF_MASK, ~acc_q[14:12] & AF_MASK};

  // Phase 0 means asserted, so a fresh press fires immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      af_ph_q <= '0;
      for (int j = 0; j < 6; j++) af_cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < 6; j++) begin
        if (!af_act[j]) begin
          af_cnt_q[j] <= '0;
          af_ph_q[j]  <= 1'b0;
        end else if (tick_q) begin
          if (af_cnt_q[j] == AW'(AF_TICKS - 1)) begin
            af_cnt_q[j] <= '0;
            af_ph_q[j]  <= ~af_ph_q[j];
          end else begin
            af_cnt_q[j] <= af_cnt_q[j] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    JOY1_OUT = acc_q[17:8];
    JOY2_OUT = acc_q[27:18];
    for (int k = 0; k < 3; k++) begin
      if (af_act[k])     JOY1_OUT[4+k] = af_ph_q[k];
      if (af_act[3+k])   JOY2_OUT[4+k] = af_ph_q[3+k];
    end
  end
`else
  logic unused_af_mask;
  assign unused_af_mask = ^AF_MASK;
  assign JOY1_OUT = acc_q[17:8];
  assign JOY2_OUT = acc_q[27:18];
`endif

endmodule

// File: tb/tb_raizing_input_cond.sv
// tb/tb_raizing_input_cond.sv - randomized scoreboard bench for raizing_input_cond
module tb_raizing_input_cond;
  localparam int KHZ = 10, DEB = 4, PULSE = 100, GAP = 100, AF = 33;

  logic       CLK = 1'b0, RESET_N = 1'b0;
  logic [3:0] COIN_RAW = '1, START_RAW = '1;
  logic [9:0] JOY1_RAW = '1, JOY2_RAW = '1;
  logic [2:0] AF_MASK = '0;
  logic [3:0] COIN_OUT, START_OUT;
  logic [9:0] JOY1_OUT, JOY2_OUT;
  logic       TICK;

  always #5 CLK = ~CLK;

  raizing_input_cond #(.CLK_KHZ(KHZ)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .COIN_RAW(COIN_RAW), .START_RAW(START_RAW),
    .JOY1_RAW(JOY1_RAW), .JOY2_RAW(JOY2_RAW), .AF_MASK(AF_MASK),
    .COIN_OUT(COIN_OUT), .START_OUT(START_OUT), .JOY1_OUT(JOY1_OUT),
    .JOY2_OUT(JOY2_OUT), .TICK(TICK)
  );

  typedef struct {int coin; int len; bit gap_chk;} coin_exp_t;
  typedef struct {int idx; bit val; int tick;} lvl_exp_t;
  coin_exp_t coin_q[$];
  lvl_exp_t  lvl_q[$];

  int checks = 0, errors = 0, tick_n = 0;
  int low_cnt[4], high_cnt[4], last_gap[4];
  logic [3:0]  prev_coin = '1;
  logic [23:0] prev_lv = '1;
  int sps[5] = '{15, 20, 25, 60, 70};

  task automatic check_coin(input int i);
    coin_exp_t e;
    checks++;
    if (coin_q.size() == 0) begin
      errors++;
      $display("FAIL coin_unexpected coin %0d low_ticks %0d, required no pulse", i, low_cnt[i]);
    end else begin
      e = coin_q.pop_front();
      if (e.coin != i || e.len != low_cnt[i] || (e.gap_chk && last_gap[i] != GAP)) begin
        errors++;
        $display("FAIL coin_pulse got coin %0d len %0d gap %0d, required coin %0d len %0d gap %0d",
                 i, low_cnt[i], last_gap[i], e.coin, e.len, e.gap_chk ? GAP : last_gap[i]);
      end
    end
  endtask

  task automatic check_lvl(input int i, input logic v);
    lvl_exp_t e;
    checks++;
    if (lvl_q.size() == 0) begin
      errors++;
      $display("FAIL level_unexpected bit %0d got %0b at tick %0d, required no change", i, v, tick_n);
    end else begin
      e = lvl_q.pop_front();
      if (e.idx != i || e.val != v || e.tick != tick_n) begin
        errors++;
        $display("FAIL level_change got bit %0d val %0b tick %0d, required bit %0d val %0b tick %0d",
                 i, v, tick_n, e.idx, e.val, e.tick);
      end
    end
  endtask

  initial begin : monitor
    logic [23:0] cur;
    forever begin
      @(negedge CLK);
      if (TICK) tick_n++;
      for (int i = 0; i < 4; i++) begin
        if (!COIN_OUT[i]) begin
          if (prev_coin[i]) begin
            last_gap[i] = high_cnt[i];
            low_cnt[i]  = 0;
          end
          if (TICK) low_cnt[i]++;
        end else begin
          if (!prev_coin[i]) begin
            check_coin(i);
            high_cnt[i] = 0;
          end
          if (TICK) high_cnt[i]++;
        end
      end
      cur = {JOY2_OUT, JOY1_OUT, START_OUT};
      for (int i = 0; i < 24; i++)
        if (cur[i] !== prev_lv[i]) check_lvl(i, cur[i]);
      prev_lv   = cur;
      prev_coin = COIN_OUT;
    end
  end

  task automatic finish_fatal(input string why);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "%s", why);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin @(negedge CLK); g++; end while (!TICK && g < 4*KHZ);
      if (!TICK) begin
        errors++;
        $display("FAIL tick_timeout got no TICK in %0d cycles, required one every %0d", 4*KHZ, KHZ);
        finish_fatal("tick lost");
      end
    end
    #1;
  endtask

  function automatic logic raw_lvl(input int idx);
    if (idx < 4) return START_RAW[idx];
    else if (idx < 14) return JOY1_RAW[idx-4];
    else return JOY2_RAW[idx-14];
  endfunction

  task automatic set_lvl(input int idx, input logic v);
    if (idx < 4) START_RAW[idx] = v;
    else if (idx < 14) JOY1_RAW[idx-4] = v;
    else JOY2_RAW[idx-14] = v;
  endtask

  task automatic check_rst();
    checks++;
    if ({COIN_OUT, START_OUT, JOY1_OUT, JOY2_OUT, TICK} !== {28'hFFFFFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h %h %b, required f f 3ff 3ff 0",
               COIN_OUT, START_OUT, JOY1_OUT, JOY2_OUT, TICK);
    end
  endtask

  task automatic check_first_tick();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!TICK && n < 3*KHZ);
    checks++;
    if (!TICK || n != KHZ) begin
      errors++;
      $display("FAIL first_tick got at cycle %0d, required %0d", n, KHZ);
    end
    #1;
  endtask

  task automatic drain(input int max_ticks);
    int t;
    t = 0;
    while ((coin_q.size() != 0 || lvl_q.size() != 0 || COIN_OUT != 4'hF) && t < max_ticks) begin
      wait_ticks(1);
      t++;
    end
    checks++;
    if (coin_q.size() != 0 || lvl_q.size() != 0) begin
      errors++;
      $display("FAIL drain got unseen coin %0d level %0d events, required 0 0", coin_q.size(), lvl_q.size());
    end
  endtask

  // Glitches shorter than DEB ticks, then a stable level that must appear DEB ticks later.
  task automatic deb_event(input int idx, input int ng);
    logic v;
    v = ~raw_lvl(idx);
    for (int g = 0; g < ng; g++) begin
      set_lvl(idx, v);
      wait_ticks($urandom_range(1, DEB-1));
      set_lvl(idx, ~v);
      wait_ticks(1);
    end
    set_lvl(idx, v);
    lvl_q.push_back('{idx, v, tick_n + DEB});
    wait_ticks(DEB + 2);
  endtask

  task automatic restore_levels();
    for (int i = 0; i < 24; i++)
      if (raw_lvl(i) == 1'b0) begin
        set_lvl(i, 1'b1);
        lvl_q.push_back('{i, 1'b1, tick_n + DEB});
      end
    wait_ticks(DEB + 2);
  endtask

  // Reference: one pulse+gap slot is PULSE+GAP ticks; up to 3 presses wait while busy.
  task automatic run_coin(input int c, input int n, input int sp);
    int free, pend, p;
    free = -1000;
    pend = 0;
    for (int k = 0; k < n; k++) begin
      p = k * sp;
      while (pend > 0 && free <= p) begin
        coin_q.push_back('{c, PULSE, 1'b1});
        free += PULSE + GAP;
        pend--;
      end
      if (free <= p) begin
        coin_q.push_back('{c, PULSE, 1'b0});
        free = p + PULSE + GAP;
      end else if (pend < 3) begin
        pend++;
      end
    end
    while (pend > 0) begin
      coin_q.push_back('{c, PULSE, 1'b1});
      pend--;
    end
    for (int k = 0; k < n; k++) begin
      COIN_RAW[c] = 1'b0;
      wait_ticks(sp / 2);
      COIN_RAW[c] = 1'b1;
      wait_ticks(sp - sp / 2);
    end
    drain(1500);
    wait_ticks(220);
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog got timeout, required run to complete");
    finish_fatal("watchdog");
  end

  initial begin
    int t0, rel, g;
    RESET_N = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    check_rst();
    RESET_N = 1'b1;
    check_first_tick();

    deb_event(0, 2);
    for (int e = 0; e < 11; e++) deb_event($urandom_range(0, 23), $urandom_range(0, 2));
    restore_levels();
    drain(20);

    AF_MASK = 3'b001;
    set_lvl(8, 1'b0);
    t0 = tick_n;
`ifdef RAIZING_AUTOFIRE_EN
    lvl_q.push_back('{8, 1'b0, t0 + DEB});
    lvl_q.push_back('{8, 1'b1, t0 + DEB + AF});
    lvl_q.push_back('{8, 1'b0, t0 + DEB + 2*AF});
`else
    lvl_q.push_back('{8, 1'b0, t0 + DEB});
`endif
    wait_ticks(90);
    set_lvl(8, 1'b1);
    lvl_q.push_back('{8, 1'b1, tick_n + DEB});
    wait_ticks(DEB + 2);
    AF_MASK = 3'b000;
    drain(20);

    coin_q.push_back('{0, PULSE, 1'b0});
    COIN_RAW[0] = 1'b0;
    wait_ticks(2000);
    COIN_RAW[0] = 1'b1;
    wait_ticks(DEB + 2);
    drain(10);

    run_coin(1, 5, 20);
    for (int s = 0; s < 2; s++)
      run_coin($urandom_range(0, 3), $urandom_range(2, 5), sps[$urandom_range(0, 4)]);

    coin_q.push_back('{0, 50, 1'b0});
    t0 = tick_n;
    COIN_RAW[0] = 1'b0;
    g = 0;
    do begin
      @(negedge CLK);
      #1;
      g++;
      rel = tick_n - t0;
      COIN_RAW[0] = !(rel < 5 || (rel >= 10 && rel < 15));
    end while (!(COIN_OUT[0] == 1'b0 && low_cnt[0] == 50) && g < 3000);
    checks++;
    if (g >= 3000) begin
      errors++;
      $display("FAIL reset_pulse_wait got no 50-tick pulse in %0d cycles, required one", g);
    end
    COIN_RAW[0] = 1'b1;
    RESET_N = 1'b0;
    #1;
    check_rst();
    repeat (3) @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    check_first_tick();
    wait_ticks(300);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
